fp16_align_stage: RTL and testbench
===================================

FP16_ALIGN_STAGE -- requirements
Module: fp16_align_stage

Interface
REQ-001 SHALL have parameter SHIFT_LIMIT, default 12, the maximum alignment shift; larger shifts flush the smaller mantissa to zero.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_a, in_b  input  16 each  IEEE half-precision operands.
REQ-005 SHALL have port in_sub  input  1  1 = compute A-B by inverting the sign of B at unpack.
REQ-006 SHALL have ports in_valid  input  1 and in_ready  output  1  upstream handshake.
REQ-007 SHALL have ports out_valid  output  1 and out_ready  input  1  downstream handshake toward the adder core.
REQ-008 SHALL have port out_sign  output  1  sign of the larger-magnitude operand.
REQ-009 SHALL have port out_eff_sub  output  1  effective sign of A xor effective sign of B.
REQ-010 SHALL have port out_exp  output  6  common exponent: bit 5 = 0, bits 4:0 = larger exponent.
REQ-011 SHALL have ports out_man_big, out_man_small  output  16 each  mantissas in extended format: [15:13] zero, [12] hidden 1, [11:2] fraction, [1:0] guard/round.
REQ-012 SHALL have port out_special  output  2  00 normal, 01 infinity, 10 bypass/zero, 11 NaN.
REQ-013 SHALL have port out_bypass  output  16  final result when out_special != 00.

Function
REQ-014 SHALL be a two-stage pipeline: S1 registers unpack, classification, compare and shift amount; S2 registers the aligned mantissas.
REQ-015 SHALL accept a transfer when in_valid && in_ready, and SHALL present the result on out_valid exactly 2 cycles later when not stalled.
REQ-016 SHALL drive in_ready = !s1_valid || s1 advances; s1 advances when !s2_valid || (out_valid && out_ready); s2 drops valid on a downstream transfer with no refill.
REQ-017 SHALL hold all outputs stable while out_valid && !out_ready; no transfer shall be lost or duplicated under any stall pattern.
REQ-018 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-019 SHALL form the effective sign of B as in_b[15] ^ in_sub.
REQ-020 SHALL classify in this priority order:
  - A NaN (exp 31, frac != 0): 11, bypass A.
  - B NaN: 11, bypass effective B.
  - expA == 0: 10, bypass effective B.
  - expB == 0: 10, bypass A.
  - both infinity with opposite effective signs: 11, bypass {A[15:1], 1}.
  - A infinity: 01, bypass A.
  - B infinity: 01, bypass effective B.
  - otherwise: 00.
REQ-021 SHALL select A as larger when expA > expB, or when the exponents are equal and fracA > fracB; otherwise B is larger (ties select B).
REQ-022 SHALL set out_special = 10 and out_bypass = 16'h0000 when the class is normal, magnitudes are equal and out_eff_sub = 1.
REQ-023 SHALL compute shift = exp_big - exp_small and logically right-shift the smaller mantissa by shift.
  - If shift > SHIFT_LIMIT, out_man_small SHALL be 0.
  - Bits shifted past bit 0 SHALL be discarded (no sticky bit).
REQ-024 SHALL drive out_man_big unshifted.
REQ-025 SHALL drive mantissa, exponent and sign outputs to 0 when out_special != 00.

Reset
REQ-026 SHALL clear s1_valid and s2_valid and drive all outputs to 0 on any cycle with rst = 1, including mid-operation; in-flight operands are discarded.
REQ-027 SHALL hold in_ready = 0 while rst = 1 and assert it in the first cycle after rst deasserts.

Verification
REQ-028 SHALL pass: 0x3C00 + 0x3C00, sub = 0 -> 2 cycles later out_exp = 15, man_big = man_small = 0x1000, eff_sub = 0, special = 00.
REQ-029 SHALL pass: 0x4000 + 0x3C00 -> out_exp = 16, man_big = 0x1000, man_small = 0x0800, sign = 0.
REQ-030 SHALL pass: 0x7800 + 0x3C00 (shift 15) -> man_small = 0; and 0x3C00 - 0x3C00 -> special = 10, bypass = 0x0000.
REQ-031 SHALL pass: 0x7E00 + 0x3C00 -> special = 11, bypass = 0x7E00; and 0x7C00 - 0x7C00 -> special = 11, bypass = 0x7C01.
REQ-032 SHALL pass: out_ready held 0 while 3 operands are offered -> 2 accepted, in_ready = 0 thereafter, outputs stable; out_ready = 1 -> results drain in order, 1 per cycle.
REQ-033 SHALL pass: rst asserted 1 cycle after accepting an operand -> out_valid never rises for it; the next operand after rst deasserts appears 2 cycles after acceptance.

Source files
------------

// File: rtl/fp16_align_stage.sv
// fp16_align_stage: two-stage front end of a half-precision adder.
// S1 unpacks, classifies, picks the larger operand and computes the
// alignment shift; S2 right-shifts the smaller mantissa into alignment.
module fp16_align_stage #(
   parameter int SHIFT_LIMIT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic        in_sub,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sign,
   output logic        out_eff_sub,
   output logic [5:0]  out_exp,
   output logic [15:0] out_man_big,
   output logic [15:0] out_man_small,
   output logic [1:0]  out_special,
   output logic [15:0] out_bypass
);

   typedef struct packed {
      logic        sign;
      logic        eff_sub;
      logic [4:0]  exp;
      logic [15:0] man_big;
      logic [15:0] man_small;
      logic [4:0]  shift;
      logic [1:0]  special;
      logic [15:0] bypass;
   } s1_t;

   typedef struct packed {
      logic        sign;
      logic        eff_sub;
      logic [5:0]  exp;
      logic [15:0] man_big;
      logic [15:0] man_small;
      logic [1:0]  special;
      logic [15:0] bypass;
   } s2_t;

   logic        s1_valid_q, s1_valid_d;
   logic        s2_valid_q, s2_valid_d;
   s1_t         s1_q, s1_d, unp;
   s2_t         s2_q, s2_d, aln, out_pay;
   logic        s1_adv, in_fire;

   logic [4:0]  exp_a, exp_b;
   logic [9:0]  frac_a, frac_b;
   logic        sgn_a, sgn_b;
   logic [15:0] eff_b;
   logic        a_nan, b_nan, a_inf, b_inf, a_big, mag_eq;

   // Field decode; B's sign is flipped here so subtraction becomes addition.
   assign exp_a  = in_a[14:10];
   assign exp_b  = in_b[14:10];
   assign frac_a = in_a[9:0];
   assign frac_b = in_b[9:0];
   assign sgn_a  = in_a[15];
   assign sgn_b  = in_b[15] ^ in_sub;
   assign eff_b  = {sgn_b, in_b[14:0]};
   assign a_nan  = (exp_a == 5'd31) && (frac_a != 10'd0);
   assign b_nan  = (exp_b == 5'd31) && (frac_b != 10'd0);
   assign a_inf  = (exp_a == 5'd31) && (frac_a == 10'd0);
   assign b_inf  = (exp_b == 5'd31) && (frac_b == 10'd0);
   // Exponent sits above fraction, so a plain magnitude compare orders them.
   assign a_big  = in_a[14:0] > in_b[14:0];
   assign mag_eq = in_a[14:0] == in_b[14:0];

   // Classify and pick the larger operand; specials carry zeroed datapath fields.
   always_comb begin
      unp = '0;
      if (a_nan) begin
         unp.special = 2'b11;  unp.bypass = in_a;
      end else if (b_nan) begin
         unp.special = 2'b11;  unp.bypass = eff_b;
      end else if (exp_a == 5'd0) begin
         unp.special = 2'b10;  unp.bypass = eff_b;
      end else if (exp_b == 5'd0) begin
         unp.special = 2'b10;  unp.bypass = in_a;
      end else if (a_inf && b_inf && (sgn_a != sgn_b)) begin
         unp.special = 2'b11;  unp.bypass = {in_a[15:1], 1'b1};
      end else if (a_inf) begin
         unp.special = 2'b01;  unp.bypass = in_a;
      end else if (b_inf) begin
         unp.special = 2'b01;  unp.bypass = eff_b;
      end else if (mag_eq && (sgn_a ^ sgn_b)) begin
         unp.special = 2'b10;  unp.bypass = 16'h0000;
      end else begin
         unp.sign      = a_big ? sgn_a : sgn_b;
         unp.eff_sub   = sgn_a ^ sgn_b;
         unp.exp       = a_big ? exp_a : exp_b;
         unp.man_big   = {3'b000, 1'b1, (a_big ? frac_a : frac_b), 2'b00};
         unp.man_small = {3'b000, 1'b1, (a_big ? frac_b : frac_a), 2'b00};
         unp.shift     = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
      end
   end

   // Alignment: shifts past the limit flush the small mantissa entirely.
   always_comb begin
      aln           = '0;
      aln.sign      = s1_q.sign;
      aln.eff_sub   = s1_q.eff_sub;
      aln.exp       = {1'b0, s1_q.exp};
      aln.man_big   = s1_q.man_big;
      aln.man_small = (int'(s1_q.shift) > SHIFT_LIMIT) ? 16'h0000
                                                       : (s1_q.man_small >> s1_q.shift);
      aln.special   = s1_q.special;
      aln.bypass    = s1_q.bypass;
   end

   // Handshake and next-state: S1 moves on whenever S2 is empty or draining.
   always_comb begin
      s1_adv     = !s2_valid_q || out_ready;
      in_ready   = !rst && (!s1_valid_q || s1_adv);
      in_fire    = in_valid && in_ready;
      s1_valid_d = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
      s1_d       = in_fire ? unp : s1_q;
      s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
      s2_d       = (s1_adv && s1_valid_q) ? aln : s2_q;
   end

   // Pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

   // Outputs forced low during reset so nothing leaks in the reset cycle itself.
   assign out_pay       = rst ? '0 : s2_q;
   assign out_valid     = s2_valid_q && !rst;
   assign out_sign      = out_pay.sign;
   assign out_eff_sub   = out_pay.eff_sub;
   assign out_exp       = out_pay.exp;
   assign out_man_big   = out_pay.man_big;
   assign out_man_small = out_pay.man_small;
   assign out_special   = out_pay.special;
   assign out_bypass    = out_pay.bypass;

endmodule

// File: tb/tb_fp16_align_stage.sv
// Bench for fp16_align_stage: reference model + scoreboard, directed cases.
module tb_fp16_align_stage;
   localparam int LIM = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_a, in_b;
   logic        in_sub, in_valid, in_ready;
   logic        out_valid, out_ready;
   logic        out_sign, out_eff_sub;
   logic [5:0]  out_exp;
   logic [15:0] out_man_big, out_man_small, out_bypass;
   logic [1:0]  out_special;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic        sign;
      logic        eff_sub;
      logic [5:0]  exp;
      logic [15:0] mb;
      logic [15:0] ms;
      logic [1:0]  special;
      logic [15:0] bypass;
   } res_t;

   res_t sb[$];

   fp16_align_stage #(.SHIFT_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_sign(out_sign), .out_eff_sub(out_eff_sub),
      .out_exp(out_exp), .out_man_big(out_man_big), .out_man_small(out_man_small),
      .out_special(out_special), .out_bypass(out_bypass)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout vectors=%0d", n_vec);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: what the outputs must be, from the number-format rules.
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
      res_t r;
      int ea, eb, fa, fb, ma, mb, eg, es, fg, fs, sh;
      logic sa, sbf;
      logic [15:0] beff;
      r = '0;
      ea = int'(a[14:10]);  eb = int'(b[14:10]);
      fa = int'(a[9:0]);    fb = int'(b[9:0]);
      sa = a[15];           sbf = b[15] ^ sub;
      beff = {sbf, b[14:0]};
      if (ea == 31 && fa != 0)                       begin r.special = 2'b11; r.bypass = a; end
      else if (eb == 31 && fb != 0)                  begin r.special = 2'b11; r.bypass = beff; end
      else if (ea == 0)                              begin r.special = 2'b10; r.bypass = beff; end
      else if (eb == 0)                              begin r.special = 2'b10; r.bypass = a; end
      else if (ea == 31 && eb == 31 && sa != sbf)    begin r.special = 2'b11; r.bypass = a | 16'h0001; end
      else if (ea == 31)                             begin r.special = 2'b01; r.bypass = a; end
      else if (eb == 31)                             begin r.special = 2'b01; r.bypass = beff; end
      else begin
         ma = ea * 1024 + fa;
         mb = eb * 1024 + fb;
         if (ma == mb && sa != sbf) begin
            r.special = 2'b10; r.bypass = 16'h0000;
         end else begin
            eg = (ma > mb) ? ea : eb;  es = (ma > mb) ? eb : ea;
            fg = (ma > mb) ? fa : fb;  fs = (ma > mb) ? fb : fa;
            sh = eg - es;
            r.sign    = (ma > mb) ? sa : sbf;
            r.eff_sub = sa ^ sbf;
            r.exp     = 6'(eg);
            r.mb      = 16'(4096 + 4 * fg);
            r.ms      = (sh > LIM) ? 16'h0000 : 16'((4096 + 4 * fs) / (1 << sh));
         end
      end
      return r;
   endfunction

   // Scoreboard: log accepted operands, check each delivered result in order.
   always @(negedge clk) begin
      res_t e, act;
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            act = {out_sign, out_eff_sub, out_exp, out_man_big, out_man_small, out_special, out_bypass};
            if (sb.size() == 0) check("out_unexpected", 64'(out_valid), 64'd0);
            else begin
               e = sb.pop_front();
               check("out_vec", 64'(act), 64'(e));
            end
         end
         if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_sub));
      end
   end

   // One operand with out_ready high: check 2-cycle latency and literal outputs.
   task automatic lat_case(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [1:0] sp, input logic [15:0] byp, input logic [5:0] e,
                           input logic [15:0] mb, input logic [15:0] ms, input logic sg,
                           input logic es);
      @(posedge clk); #1;
      in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); check("acc_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk); check("lat1_valid", 64'(out_valid), 64'd0);
      @(negedge clk); check("lat2_valid", 64'(out_valid), 64'd1);
      check("lit_special", 64'(out_special), 64'(sp));
      check("lit_bypass", 64'(out_bypass), 64'(byp));
      check("lit_exp", 64'(out_exp), 64'(e));
      check("lit_man_big", 64'(out_man_big), 64'(mb));
      check("lit_man_small", 64'(out_man_small), 64'(ms));
      check("lit_sign", 64'(out_sign), 64'(sg));
      check("lit_eff_sub", 64'(out_eff_sub), 64'(es));
   endtask

   // Offer one operand under a random stall pattern until accepted (bounded).
   task automatic push_vec(input logic [15:0] a, input logic [15:0] b, input logic s);
      bit acc;
      acc = 1'b0;
      in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
      for (int k = 0; k < 60; k++) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
   endtask

   logic [32:0] vt [16] = '{
      {16'h3C00, 16'h3C00, 1'b0}, {16'h4000, 16'h3C00, 1'b0}, {16'h3C00, 16'h4000, 1'b1},
      {16'h7800, 16'h3C00, 1'b0}, {16'h6C00, 16'h3C00, 1'b0}, {16'h7000, 16'h3C00, 1'b0},
      {16'h3C00, 16'h3C00, 1'b1}, {16'h7E00, 16'h3C00, 1'b0}, {16'h3C00, 16'h7D00, 1'b0},
      {16'h0000, 16'hC000, 1'b1}, {16'h3555, 16'h0000, 1'b0}, {16'h7C00, 16'hFC00, 1'b0},
      {16'hFC00, 16'h3C00, 1'b1}, {16'h3C00, 16'h7C00, 1'b1}, {16'h5A3F, 16'h5A40, 1'b1},
      {16'h4BFF, 16'h3801, 1'b0}
   };

   initial begin
      logic [57:0] snap, cur;
      rst = 1'b1; in_a = '0; in_b = '0; in_sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      // Reset state
      repeat (2) begin
         @(negedge clk);
         check("rst_in_ready", 64'(in_ready), 64'd0);
         check("rst_out_valid", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk); check("post_rst_ready", 64'(in_ready), 64'd1);

      // Directed literal cases
      lat_case(16'h3C00, 16'h3C00, 1'b0, 2'b00, 16'h0000, 6'd15, 16'h1000, 16'h1000, 1'b0, 1'b0);
      lat_case(16'h4000, 16'h3C00, 1'b0, 2'b00, 16'h0000, 6'd16, 16'h1000, 16'h0800, 1'b0, 1'b0);
      lat_case(16'h7800, 16'h3C00, 1'b0, 2'b00, 16'h0000, 6'd30, 16'h1000, 16'h0000, 1'b0, 1'b0);
      lat_case(16'h3C00, 16'h3C00, 1'b1, 2'b10, 16'h0000, 6'd0,  16'h0000, 16'h0000, 1'b0, 1'b0);
      lat_case(16'h7E00, 16'h3C00, 1'b0, 2'b11, 16'h7E00, 6'd0,  16'h0000, 16'h0000, 1'b0, 1'b0);
      lat_case(16'h7C00, 16'h7C00, 1'b1, 2'b11, 16'h7C01, 6'd0,  16'h0000, 16'h0000, 1'b0, 1'b0);
      lat_case(16'h6C00, 16'h3C00, 1'b0, 2'b00, 16'h0000, 6'd27, 16'h1000, 16'h0001, 1'b0, 1'b0);
      lat_case(16'h7000, 16'h3C00, 1'b0, 2'b00, 16'h0000, 6'd28, 16'h1000, 16'h0000, 1'b0, 1'b0);
      lat_case(16'h3C00, 16'h4200, 1'b1, 2'b00, 16'h0000, 6'd16, 16'h1800, 16'h0800, 1'b1, 1'b1);
      lat_case(16'h0000, 16'hC000, 1'b0, 2'b10, 16'hC000, 6'd0,  16'h0000, 16'h0000, 1'b0, 1'b0);

      // Stall: three offered with out_ready low, two accepted, outputs frozen
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h3C00; in_sub = 1'b0;
      @(negedge clk); check("stall_acc1", 64'(in_ready), 64'd1);
      @(posedge clk); #1; in_a = 16'h3C00; in_b = 16'h4200; in_sub = 1'b1;
      @(negedge clk); check("stall_acc2", 64'(in_ready), 64'd1);
      @(posedge clk); #1; in_a = 16'h7800; in_b = 16'h3C00; in_sub = 1'b0;
      @(negedge clk);
      check("stall_block", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      snap = {out_sign, out_eff_sub, out_exp, out_man_big, out_man_small, out_special, out_bypass};
      repeat (3) begin
         @(negedge clk);
         cur = {out_sign, out_eff_sub, out_exp, out_man_big, out_man_small, out_special, out_bypass};
         check("stall_block_hold", 64'(in_ready), 64'd0);
         check("stall_stable", 64'(cur), 64'(snap));
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(negedge clk);
      check("drain_ready", 64'(in_ready), 64'd1);
      check("drain_v1", 64'(out_valid), 64'd1);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk); check("drain_v2", 64'(out_valid), 64'd1);
      @(negedge clk); check("drain_v3", 64'(out_valid), 64'd1);
      @(negedge clk); check("drain_empty", 64'(out_valid), 64'd0);
      check("drain_sb", 64'(sb.size()), 64'd0);

      // Reset one cycle after accepting: the operand must vanish
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h3C00; in_sub = 1'b0;
      @(posedge clk); #1; in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ready", 64'(in_ready), 64'd0);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("after_rst_ready", 64'(in_ready), 64'd1);
      check("after_rst_valid0", 64'(out_valid), 64'd0);
      @(negedge clk); check("after_rst_valid1", 64'(out_valid), 64'd0);
      lat_case(16'h4000, 16'h3C00, 1'b0, 2'b00, 16'h0000, 6'd16, 16'h1000, 16'h0800, 1'b0, 1'b0);

      // Vector table streamed under random back-pressure, checked by the scoreboard
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) push_vec(vt[i][32:17], vt[i][16:1], vt[i][0]);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("stream_sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
